// File: rtl/coherence_bus_pkg.sv
// Types and helpers for the N-core coherence bus controller.
package coherence_bus_pkg;
  localparam int MAX_CPUS = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE, IFETCH, WB, SNOOP, SNOOP_RSP, C2C, MEMLD, INV
  } bus_state_t;

  // First set bit of vec at or after ptr, wrapping; bits above the core count must be zero.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                               input logic [MAX_CPUS-1:0] vec);
    logic [IDX_W-1:0] idx;
    rr_next = ptr;
    for (int k = MAX_CPUS - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (vec[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: the machine word and the RAM handshake state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
module rr_arbiter
  import coherence_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);
  logic [MAX_CPUS-1:0] vec;
  logic [IDX_W-1:0]    sel;

  always_comb begin
    vec          = '0;
    vec[N-1:0]   = req_i;
    sel          = rr_next(IDX_W'(ptr_i), vec);
    idx_o        = sel[$clog2(N)-1:0];
    valid_o      = |req_i;
    gnt_o        = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// N-core coherent bus controller: arbitrates fetches, reads, writebacks and
// invalidations onto one RAM port, with snooping and cache-to-cache supply.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import coherence_bus_pkg::*;
#(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CPUS-1:0] iREN_i,
  input  word_t           iaddr_i [CPUS],
  output logic [CPUS-1:0] iwait_o,
  output word_t           iload_o [CPUS],
  input  logic [CPUS-1:0] dREN_i,
  input  logic [CPUS-1:0] dWEN_i,
  input  word_t           daddr_i [CPUS],
  input  word_t           dstore_i [CPUS],
  output logic [CPUS-1:0] dwait_o,
  output word_t           dload_o [CPUS],
  input  logic [CPUS-1:0] cctrans_i,
  input  logic [CPUS-1:0] ccwrite_i,
  output logic [CPUS-1:0] ccwait_o,
  output logic [CPUS-1:0] ccinv_o,
  output word_t           ccsnoopaddr_o [CPUS],
  input  word_t           ramload_i,
  input  ramstate_t       ramstate_i,
  output word_t           ramaddr_o,
  output word_t           ramstore_o,
  output logic            ramREN_o,
  output logic            ramWEN_o
);
  localparam int IW = $clog2(CPUS);
  localparam int WW = $clog2(BLKWORDS) + 1;
  localparam logic [IW-1:0] LAST_CPU = IW'(CPUS - 1);
  localparam logic [WW-1:0] BLK_CNT  = WW'(BLKWORDS);

  bus_state_t      state_q, state_d;
  logic [IW-1:0]   req_q, req_d, owner_q, owner_d;
  logic [IW-1:0]   dptr_q, dptr_d, iptr_q, iptr_d;
  logic [WW-1:0]   wcnt_q, wcnt_d, wnext;

  logic [CPUS-1:0] dreq, dgnt, ignt, others;
  logic [IW-1:0]   didx, iidx, ownSel;
  logic            dvalid, ivalid, ownFound, access, wordDone;

  assign dreq   = dREN_i | dWEN_i | (cctrans_i & ccwrite_i);
  assign others = ~(CPUS'(1) << req_q);
  assign access = (ramstate_i == ACCESS);
  assign wnext  = wcnt_q + 1'b1;

  rr_arbiter #(.N(CPUS)) u_darb (
    .req_i(dreq), .ptr_i(dptr_q), .gnt_o(dgnt), .idx_o(didx), .valid_o(dvalid)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .req_i(iREN_i), .ptr_i(iptr_q), .gnt_o(ignt), .idx_o(iidx), .valid_o(ivalid)
  );

  // Lowest-numbered snooper reporting a Modified copy supplies the block.
  always_comb begin
    ownFound = 1'b0;
    ownSel   = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (others[j] && cctrans_i[j] && ccwrite_i[j]) begin
        ownFound = 1'b1;
        ownSel   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= '0;
      dptr_q  <= '0;
      iptr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    owner_d    = owner_q;
    dptr_d     = dptr_q;
    iptr_d     = iptr_q;
    wcnt_d     = wcnt_q;
    wordDone   = 1'b0;
    iwait_o    = '1;
    dwait_o    = '1;
    ccwait_o   = '0;
    ccinv_o    = '0;
    ramaddr_o  = '0;
    ramstore_o = '0;
    ramREN_o   = 1'b0;
    ramWEN_o   = 1'b0;
    for (int j = 0; j < CPUS; j++) begin
      iload_o[j]       = '0;
      dload_o[j]       = '0;
      ccsnoopaddr_o[j] = '0;
    end

    // ERROR and BUSY fall through without ACCESS, so the state and command simply repeat.
    case (state_q)
      IDLE: begin
        if (dvalid) begin
          req_d  = didx;
          dptr_d = (didx == LAST_CPU) ? '0 : didx + 1'b1;
          if (|(dWEN_i & dgnt))      state_d = WB;
          else if (|(dREN_i & dgnt)) state_d = SNOOP;
          else                       state_d = INV;
        end else if (ivalid && (iREN_i & ignt) != '0) begin
          req_d   = iidx;
          iptr_d  = (iidx == LAST_CPU) ? '0 : iidx + 1'b1;
          state_d = IFETCH;
        end
      end
      IFETCH: begin
        ramREN_o  = 1'b1;
        ramaddr_o = iaddr_i[req_q];
        if (access) begin
          iwait_o[req_q] = 1'b0;
          iload_o[req_q] = ramload_i;
          state_d        = IDLE;
        end
      end
      WB: begin
        ramWEN_o   = 1'b1;
        ramaddr_o  = daddr_i[req_q];
        ramstore_o = dstore_i[req_q];
        if (access) begin
          dwait_o[req_q] = 1'b0;
          wordDone       = 1'b1;
        end
      end
      SNOOP, SNOOP_RSP: begin
        ccwait_o = others;
        ccinv_o  = others & {CPUS{ccwrite_i[req_q]}};
        for (int j = 0; j < CPUS; j++) begin
          if (others[j]) ccsnoopaddr_o[j] = daddr_i[req_q];
        end
        if (state_q == SNOOP) begin
          state_d = SNOOP_RSP;
        end else if (ownFound) begin
          owner_d = ownSel;
          state_d = C2C;
        end else begin
          state_d = MEMLD;
        end
      end
      C2C: begin
        dload_o[req_q]    = dstore_i[owner_q];
        ramWEN_o          = 1'b1;
        ramaddr_o         = daddr_i[owner_q];
        ramstore_o        = dstore_i[owner_q];
        ccwait_o[owner_q] = 1'b1;
        ccinv_o           = others & {CPUS{ccwrite_i[req_q]}};
        if (access) begin
          dwait_o[req_q]   = 1'b0;
          dwait_o[owner_q] = 1'b0;
          wordDone         = 1'b1;
        end
      end
      MEMLD: begin
        ramREN_o  = 1'b1;
        ramaddr_o = daddr_i[req_q];
        ccinv_o   = others & {CPUS{ccwrite_i[req_q]}};
        if (access) begin
          dload_o[req_q] = ramload_i;
          dwait_o[req_q] = 1'b0;
          wordDone       = 1'b1;
        end
      end
      INV: begin
        ccinv_o        = others;
        dwait_o[req_q] = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wordDone) begin
      if (wnext == BLK_CNT) begin
        wcnt_d  = '0;
        state_d = IDLE;
      end else begin
        wcnt_d = wnext;
      end
    end
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (4 cores, 2-word blocks): cycle vector
// table plus hand-written cache-to-cache, read-exclusive and reset sequences.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;
  import coherence_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [3:0] iwait, dwait, ccwait, ccinv;
  word_t      iaddr [4], iload [4], daddr [4], dstore [4], dload [4], ccsnoopaddr [4];
  word_t      ramload, ramaddr, ramstore;
  ramstate_t  ramstate;
  logic       ramREN, ramWEN;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] dren, dwen, iren, cct, ccw;
    ramstate_t  rs;
    logic [3:0] edw, eiw, eci, ecw;
    logic       eren, ewen;
    word_t      eaddr, estore;
    int         eld, eil;
  } vec_t;

  vec_t tbl [$];

  coherence_bus_ctrl #(.CPUS(4), .BLKWORDS(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .iREN_i(iREN), .iaddr_i(iaddr), .iwait_o(iwait), .iload_o(iload),
    .dREN_i(dREN), .dWEN_i(dWEN), .daddr_i(daddr), .dstore_i(dstore),
    .dwait_o(dwait), .dload_o(dload),
    .cctrans_i(cctrans), .ccwrite_i(ccwrite), .ccwait_o(ccwait), .ccinv_o(ccinv),
    .ccsnoopaddr_o(ccsnoopaddr),
    .ramload_i(ramload), .ramstate_i(ramstate), .ramaddr_o(ramaddr),
    .ramstore_o(ramstore), .ramREN_o(ramREN), .ramWEN_o(ramWEN)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic [3:0] dren, logic [3:0] dwen, logic [3:0] iren,
                               logic [3:0] cct, logic [3:0] ccw, ramstate_t rs,
                               logic [3:0] edw, logic [3:0] eiw, logic [3:0] eci,
                               logic [3:0] ecw, logic eren, logic ewen,
                               word_t eaddr, word_t estore, int eld, int eil);
    vec_t v;
    v.dren = dren; v.dwen = dwen; v.iren = iren; v.cct = cct; v.ccw = ccw; v.rs = rs;
    v.edw = edw; v.eiw = eiw; v.eci = eci; v.ecw = ecw; v.eren = eren; v.ewen = ewen;
    v.eaddr = eaddr; v.estore = estore; v.eld = eld; v.eil = eil;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    dREN = v.dren; dWEN = v.dwen; iREN = v.iren;
    cctrans = v.cct; ccwrite = v.ccw; ramstate = v.rs;
  endtask

  task automatic checkRow(input int r, input vec_t v);
    string p;
    p = $sformatf("row%0d", r);
    checkOutput({p, " dwait"}, 32'(dwait), 32'(v.edw));
    checkOutput({p, " iwait"}, 32'(iwait), 32'(v.eiw));
    checkOutput({p, " ccinv"}, 32'(ccinv), 32'(v.eci));
    checkOutput({p, " ccwait"}, 32'(ccwait), 32'(v.ecw));
    checkOutput({p, " ramREN"}, 32'(ramREN), 32'(v.eren));
    checkOutput({p, " ramWEN"}, 32'(ramWEN), 32'(v.ewen));
    checkOutput({p, " ramaddr"}, ramaddr, v.eaddr);
    checkOutput({p, " ramstore"}, ramstore, v.estore);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s dload%0d", p, k), dload[k], (k == v.eld) ? ramload : 32'h0);
      checkOutput($sformatf("%s iload%0d", p, k), iload[k], (k == v.eil) ? ramload : 32'h0);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " dwait"}, 32'(dwait), 32'hF);
    checkOutput({tag, " iwait"}, 32'(iwait), 32'hF);
    checkOutput({tag, " ccwait"}, 32'(ccwait), 32'h0);
    checkOutput({tag, " ccinv"}, 32'(ccinv), 32'h0);
    checkOutput({tag, " ramREN"}, 32'(ramREN), 32'h0);
    checkOutput({tag, " ramWEN"}, 32'(ramWEN), 32'h0);
    checkOutput({tag, " ramaddr"}, ramaddr, 32'h0);
    checkOutput({tag, " ramstore"}, ramstore, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s dload%0d", tag, k), dload[k], 32'h0);
      checkOutput($sformatf("%s iload%0d", tag, k), iload[k], 32'h0);
      checkOutput($sformatf("%s snoopaddr%0d", tag, k), ccsnoopaddr[k], 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    ramstate = FREE;
    ramload  = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      daddr[k]  = 32'h1000 + 32'(k) * 16;
      dstore[k] = 32'hA000 + 32'(k);
      iaddr[k]  = 32'h4000 + 32'(k) * 4;
    end

    // Round-robin among cores 0, 1, 3, all served from memory.
    tbl.push_back(mkv(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b1110, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b1110, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b1110, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1000, 0, 0, -1));
    tbl.push_back(mkv(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b1110, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1000, 0, 0, -1));
    tbl.push_back(mkv(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b1101, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b1101, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b1101, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1010, 0, 1, -1));
    tbl.push_back(mkv(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b1101, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1010, 0, 1, -1));
    tbl.push_back(mkv(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b0111, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'b0111, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b0111, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1030, 0, 3, -1));
    tbl.push_back(mkv(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'b0111, 4'hF, 4'h0, 4'h0, 1, 0, 32'h1030, 0, 3, -1));
    // Writeback beats fetch; two ERROR cycles hold the writeback; fetch follows.
    tbl.push_back(mkv(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0, ERROR, 4'hF, 4'hF, 4'h0, 4'h0, 0, 1, 32'h1010, 32'hA001, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0, ERROR, 4'hF, 4'hF, 4'h0, 4'h0, 0, 1, 32'h1010, 32'hA001, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0, ACCESS, 4'b1101, 4'hF, 4'h0, 4'h0, 0, 1, 32'h1010, 32'hA001, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0010, 4'b0001, 4'b0, 4'b0, ACCESS, 4'b1101, 4'hF, 4'h0, 4'h0, 0, 1, 32'h1010, 32'hA001, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, ACCESS, 4'hF, 4'b1110, 4'h0, 4'h0, 1, 0, 32'h4000, 0, -1, 0));
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    // Invalidate-only from core 3.
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0, 4'b1000, 4'b1000, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0, 4'b1000, 4'b1000, ACCESS, 4'b0111, 4'hF, 4'b0111, 4'h0, 0, 0, 0, 0, -1, -1));
    tbl.push_back(mkv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, ACCESS, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, -1, -1));

    repeat (2) @(negedge clk);
    #1 checkReset("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1 checkRow(i, tbl[i]);
    end
    checkOutput("rr dptr", 32'(dut.dptr_q), 32'h0);
    for (int i = 15; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1 checkRow(i, tbl[i]);
    end

    // Cache-to-cache: core 1 holds 0x200 Modified, core 0 reads it.
    @(negedge clk);
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    #1 checkOutput("c2c idle dwait", 32'(dwait), 32'hF);
    @(negedge clk);
    #1 checkOutput("c2c snoop ccwait", 32'(ccwait), 32'b1110);
    checkOutput("c2c snoopaddr1", ccsnoopaddr[1], 32'h200);
    @(negedge clk);
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hDEAD;
    #1 checkOutput("c2c rsp ccwait", 32'(ccwait), 32'b1110);
    @(negedge clk);
    #1 checkOutput("c2c w0 dload0", dload[0], 32'hDEAD);
    checkOutput("c2c w0 ramWEN", 32'(ramWEN), 32'h1);
    checkOutput("c2c w0 ramaddr", ramaddr, 32'h200);
    checkOutput("c2c w0 ramstore", ramstore, 32'hDEAD);
    checkOutput("c2c w0 dwait", 32'(dwait), 32'b1100);
    checkOutput("c2c w0 ccwait", 32'(ccwait), 32'b0010);
    checkOutput("c2c w0 ccinv", 32'(ccinv), 32'h0);
    @(negedge clk);
    daddr[0] = 32'h204; daddr[1] = 32'h204; dstore[1] = 32'hBEEF;
    #1 checkOutput("c2c w1 dload0", dload[0], 32'hBEEF);
    checkOutput("c2c w1 ramaddr", ramaddr, 32'h204);
    checkOutput("c2c w1 ramstore", ramstore, 32'hBEEF);
    checkOutput("c2c w1 dwait", 32'(dwait), 32'b1100);
    checkOutput("c2c w1 ccinv", 32'(ccinv), 32'h0);
    @(negedge clk);
    dREN = '0; cctrans = '0; ccwrite = '0;
    #1 checkOutput("c2c done dwait", 32'(dwait), 32'hF);
    checkOutput("c2c done ramWEN", 32'(ramWEN), 32'h0);

    // Read-exclusive from core 0: others invalidated until the block completes.
    @(negedge clk);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h300;
    #1 checkOutput("rdx idle ccinv", 32'(ccinv), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("rdx c%0d ccinv", c), 32'(ccinv), 32'b1110);
      if (c >= 2) begin
        checkOutput($sformatf("rdx c%0d dwait", c), 32'(dwait), 32'b1110);
        checkOutput($sformatf("rdx c%0d dload0", c), dload[0], ramload);
      end
    end
    @(negedge clk);
    dREN = '0; cctrans = '0; ccwrite = '0;
    #1 checkOutput("rdx done ccinv", 32'(ccinv), 32'h0);

    // Reset asserted during the first memory word of core 2's read.
    @(negedge clk);
    dREN[2] = 1'b1; daddr[2] = 32'h100;
    repeat (3) @(negedge clk);
    #1 checkOutput("rst memld ramREN", 32'(ramREN), 32'h1);
    checkOutput("rst memld ramaddr", ramaddr, 32'h100);
    checkOutput("rst memld dwait", 32'(dwait), 32'b1011);
    #2 rst = 1'b1;
    #1 checkReset("midread");
    @(negedge clk) rst = 1'b0;
    dREN = '0;
    #1 checkOutput("rst release state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst release wcnt", 32'(dut.wcnt_q), 32'h0);
    checkOutput("rst release dptr", 32'(dut.dptr_q), 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
